// File: rtl/vga_barrido_pkg.sv
// Shared raster timing constants for the scan generator and the text-address
// stage. Both stages read X0/Y0 from here so their window origins agree.
package vga_pkg;
  localparam int H_SYNC  = 128;
  localparam int H_BACK  = 88;
  localparam int H_VIS   = 800;
  localparam int H_FRONT = 40;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_VIS   = 480;
  localparam int V_FRONT = 10;

  localparam int H_TOT = H_SYNC + H_BACK + H_VIS + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_VIS + V_FRONT;
  localparam int X0    = H_SYNC + H_BACK;
  localparam int Y0    = V_SYNC + V_BACK;

  localparam int TXT_W   = 32;
  localparam int TXT_H   = 32;
  localparam int DIV_DEF = 2;

  localparam int CW_COL = 11;
  localparam int CW_FIL = 10;

  typedef logic [CW_COL-1:0] col_t;
  typedef logic [CW_FIL-1:0] fil_t;

  // Width of a modulo-n counter, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vga_barrido_if.sv
// Raster outputs bundled for the downstream address stage.
interface vga_barrido_if;
  import vga_pkg::*;
  logic tick;
  col_t Columnas;
  fil_t Filas;
  logic hsync;
  logic vsync;
  logic visible;
  logic en_texto;
  logic inicio_cuadro;

  modport master (output tick, Columnas, Filas, hsync, vsync, visible,
                  en_texto, inicio_cuadro);
  modport slave  (input  tick, Columnas, Filas, hsync, vsync, visible,
                  en_texto, inicio_cuadro);
endinterface

// File: rtl/vga_contador_eje.sv
// One raster axis: count register with sync decode, plus the visible/window
// decode of the value the counter is about to take, so the caller can
// register those flags alongside the count.
module vga_contador_eje #(
  parameter int W     = 11,
  parameter int SYNC  = 128,
  parameter int BACK  = 88,
  parameter int VIS   = 800,
  parameter int FRONT = 40,
  parameter int WIN   = 32,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_wrap,
  output logic [W-1:0] o_cnt,
  output logic         o_sync,
  output logic         o_vis_nxt,
  output logic         o_win_nxt,
  output logic         o_tc
);
  localparam int TOT = SYNC + BACK + VIS + FRONT;
  localparam logic [W-1:0] L_SYNC = W'(SYNC);
  localparam logic [W-1:0] L_P0   = W'(SYNC + BACK);
  localparam logic [W-1:0] L_VEND = W'(SYNC + BACK + VIS);
  localparam logic [W-1:0] L_WEND = W'(SYNC + BACK + WIN);
  localparam logic [W-1:0] L_LAST = W'(TOT - 1);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_nxt;
  logic         r_sync;

  // Next count: wrap beats enable, otherwise hold.
  always_comb begin
    w_nxt = r_cnt;
    if (i_wrap)    w_nxt = '0;
    else if (i_en) w_nxt = r_cnt + W'(1);
  end

  // Count and sync registered together; count 0 is the first sync unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_sync <= SYNC_POL;
    end else begin
      r_cnt  <= w_nxt;
      r_sync <= (w_nxt < L_SYNC) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_sync    = r_sync;
  assign o_vis_nxt = (w_nxt >= L_P0) && (w_nxt < L_VEND);
  assign o_win_nxt = (w_nxt >= L_P0) && (w_nxt < L_WEND);
  assign o_tc      = (r_cnt == L_LAST);
endmodule

// File: rtl/vga_barrido.sv
// Raster timing generator: pixel-tick divider, horizontal/vertical counters,
// registered sync, visible, text-window and frame-start flags.
module vga_barrido #(
  parameter int DIV      = vga_pkg::DIV_DEF,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BACK   = vga_pkg::H_BACK,
  parameter int H_VIS    = vga_pkg::H_VIS,
  parameter int H_FRONT  = vga_pkg::H_FRONT,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BACK   = vga_pkg::V_BACK,
  parameter int V_VIS    = vga_pkg::V_VIS,
  parameter int V_FRONT  = vga_pkg::V_FRONT,
  parameter bit SYNC_POL = 1'b0,
  parameter int TXT_W    = vga_pkg::TXT_W,
  parameter int TXT_H    = vga_pkg::TXT_H
) (
  input  logic          clk,
  input  logic          reset,
  vga_barrido_if.master o_vga
);
  import vga_pkg::*;

  localparam int DW = cnt_w(DIV);

  logic [DW-1:0]     r_div;
  logic              w_fire;
  logic              r_tick;
  logic              r_visible;
  logic              r_en_texto;
  logic              r_inicio;
  logic [CW_COL-1:0] w_col;
  logic [CW_FIL-1:0] w_fil;
  logic              w_h_sync, w_v_sync;
  logic              w_h_vis, w_v_vis;
  logic              w_h_win, w_v_win;
  logic              w_h_tc, w_v_tc;
  logic              w_h_wrap, w_v_en, w_v_wrap;

  // The edge on which the divider sits at DIV-1 is the pixel advance edge.
  assign w_fire   = (r_div == DW'(DIV - 1));
  assign w_h_wrap = w_fire & w_h_tc;
  assign w_v_en   = w_h_wrap;
  assign w_v_wrap = w_h_wrap & w_v_tc;

  // Modulo-DIV divider; reset drops it to phase 0 whatever its phase was.
  always_ff @(posedge clk) begin
    if (reset)       r_div <= '0;
    else if (w_fire) r_div <= '0;
    else             r_div <= r_div + DW'(1);
  end

  vga_contador_eje #(
    .W(CW_COL), .SYNC(H_SYNC), .BACK(H_BACK), .VIS(H_VIS), .FRONT(H_FRONT),
    .WIN(TXT_W), .SYNC_POL(SYNC_POL)
  ) u_h (
    .clk(clk), .reset(reset), .i_en(w_fire), .i_wrap(w_h_wrap),
    .o_cnt(w_col), .o_sync(w_h_sync), .o_vis_nxt(w_h_vis),
    .o_win_nxt(w_h_win), .o_tc(w_h_tc)
  );

  vga_contador_eje #(
    .W(CW_FIL), .SYNC(V_SYNC), .BACK(V_BACK), .VIS(V_VIS), .FRONT(V_FRONT),
    .WIN(TXT_H), .SYNC_POL(SYNC_POL)
  ) u_v (
    .clk(clk), .reset(reset), .i_en(w_v_en), .i_wrap(w_v_wrap),
    .o_cnt(w_fil), .o_sync(w_v_sync), .o_vis_nxt(w_v_vis),
    .o_win_nxt(w_v_win), .o_tc(w_v_tc)
  );

  // Area flags and pulses registered on the same edge as the counters,
  // decoded from the counts being loaded so they describe the new position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick     <= 1'b0;
      r_visible  <= 1'b0;
      r_en_texto <= 1'b0;
      r_inicio   <= 1'b0;
    end else begin
      r_tick     <= w_fire;
      r_visible  <= w_h_vis & w_v_vis;
      r_en_texto <= w_h_win & w_v_win;
      r_inicio   <= w_v_wrap;
    end
  end

  assign o_vga.tick          = r_tick;
  assign o_vga.Columnas      = w_col;
  assign o_vga.Filas         = w_fil;
  assign o_vga.hsync         = w_h_sync;
  assign o_vga.vsync         = w_v_sync;
  assign o_vga.visible       = r_visible;
  assign o_vga.en_texto      = r_en_texto;
  assign o_vga.inicio_cuadro = r_inicio;
endmodule

// File: tb/tb_vga_barrido.sv
// Bench for vga_barrido: three builds (DIV=2 default geometry, DIV=1 default
// geometry, DIV=4 reduced geometry) exercised one after another.
module tb_vga_barrido;
  import vga_pkg::*;

  typedef struct {
    int sel; int col; int row;
    bit hs; bit vs; bit vis; bit txt;
  } vec_t;

  typedef struct {
    int col; int row;
    bit tick; bit hs; bit vs; bit vis; bit txt; bit ini;
  } obs_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  always #5 clk = ~clk;

  vga_barrido_if if0 ();
  vga_barrido_if if1 ();
  vga_barrido_if if2 ();

  vga_barrido #(.DIV(2)) u0 (.clk(clk), .reset(rst0), .o_vga(if0));
  vga_barrido #(.DIV(1)) u1 (.clk(clk), .reset(rst1), .o_vga(if1));
  vga_barrido #(
    .DIV(4), .H_SYNC(4), .H_BACK(3), .H_VIS(10), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .V_VIS(6), .V_FRONT(1),
    .SYNC_POL(1'b0), .TXT_W(4), .TXT_H(3)
  ) u2 (.clk(clk), .reset(rst2), .o_vga(if2));

  int HT[3] = '{1056, 1056, 19};
  int DV[3] = '{2, 1, 4};

  int n_cmp = 0;
  int n_err = 0;
  int sel = 0;
  int k = 0;
  int ini_q[$];
  vec_t tbl[$];

  function automatic obs_t get(input int s);
    obs_t o;
    case (s)
      0: o = '{int'(if0.Columnas), int'(if0.Filas), if0.tick, if0.hsync,
               if0.vsync, if0.visible, if0.en_texto, if0.inicio_cuadro};
      1: o = '{int'(if1.Columnas), int'(if1.Filas), if1.tick, if1.hsync,
               if1.vsync, if1.visible, if1.en_texto, if1.inicio_cuadro};
      default: o = '{int'(if2.Columnas), int'(if2.Filas), if2.tick, if2.hsync,
               if2.vsync, if2.visible, if2.en_texto, if2.inicio_cuadro};
    endcase
    return o;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each edge.
  task automatic adv(input int n);
    obs_t o;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      k++;
      o = get(sel);
      if (o.ini) ini_q.push_back(k);
    end
  endtask

  task automatic goto_n(input int n);
    int tk;
    tk = n * DV[sel];
    if (tk > k) adv(tk - k);
  endtask

  task automatic chk_rst(input string p);
    obs_t o;
    o = get(sel);
    chk({p, "_col"}, o.col, 0);
    chk({p, "_row"}, o.row, 0);
    chk({p, "_hs"}, o.hs, 0);
    chk({p, "_vs"}, o.vs, 0);
    chk({p, "_vis"}, o.vis, 0);
    chk({p, "_txt"}, o.txt, 0);
    chk({p, "_tick"}, o.tick, 0);
    chk({p, "_ini"}, o.ini, 0);
  endtask

  task automatic run_table(input int s);
    obs_t o;
    foreach (tbl[i]) begin
      if (tbl[i].sel == s) begin
        goto_n(tbl[i].row * HT[s] + tbl[i].col);
        o = get(s);
        chk($sformatf("v%0d_col", i), o.col, tbl[i].col);
        chk($sformatf("v%0d_row", i), o.row, tbl[i].row);
        chk($sformatf("v%0d_hs", i), o.hs, tbl[i].hs);
        chk($sformatf("v%0d_vs", i), o.vs, tbl[i].vs);
        chk($sformatf("v%0d_vis", i), o.vis, tbl[i].vis);
        chk($sformatf("v%0d_txt", i), o.txt, tbl[i].txt);
        chk($sformatf("v%0d_tick", i), o.tick, 1);
      end
    end
  endtask

  initial begin
    obs_t o;
    int bad, lines, prev_row, n, er;

    // sel, col, row, hsync, vsync, visible, en_texto
    tbl.push_back('{0, 127, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 128, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 215, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 216, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 1055, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 2, 0, 1, 0, 0});
    tbl.push_back('{0, 128, 2, 1, 1, 0, 0});
    tbl.push_back('{2, 3, 1, 0, 0, 0, 0});
    tbl.push_back('{2, 4, 2, 1, 1, 0, 0});
    tbl.push_back('{2, 6, 5, 1, 1, 0, 0});
    tbl.push_back('{2, 7, 5, 1, 1, 1, 1});
    tbl.push_back('{2, 10, 5, 1, 1, 1, 1});
    tbl.push_back('{2, 11, 5, 1, 1, 1, 0});
    tbl.push_back('{2, 16, 5, 1, 1, 1, 0});
    tbl.push_back('{2, 17, 5, 1, 1, 0, 0});
    tbl.push_back('{2, 7, 7, 1, 1, 1, 1});
    tbl.push_back('{2, 10, 7, 1, 1, 1, 1});
    tbl.push_back('{2, 7, 8, 1, 1, 1, 0});
    tbl.push_back('{2, 8, 10, 1, 1, 1, 0});
    tbl.push_back('{2, 8, 11, 1, 1, 0, 0});
    tbl.push_back('{1, 216, 34, 1, 1, 0, 0});
    tbl.push_back('{1, 215, 35, 1, 1, 0, 0});
    tbl.push_back('{1, 216, 35, 1, 1, 1, 1});
    tbl.push_back('{1, 247, 35, 1, 1, 1, 1});
    tbl.push_back('{1, 248, 35, 1, 1, 1, 0});
    tbl.push_back('{1, 1015, 35, 1, 1, 1, 0});
    tbl.push_back('{1, 1016, 35, 1, 1, 0, 0});
    tbl.push_back('{1, 215, 40, 1, 1, 0, 0});
    tbl.push_back('{1, 216, 40, 1, 1, 1, 1});

    // ---- DIV=2, default geometry ----
    sel = 0;
    adv(2);
    chk_rst("rst0");
    rst0 = 1'b0; k = 0; ini_q.delete();
    adv(1);
    o = get(0);
    chk("idle_col", o.col, 0);
    chk("idle_tick", o.tick, 0);
    chk("idle_hs", o.hs, 0);
    adv(1);
    o = get(0);
    chk("first_tick", o.tick, 1);
    chk("first_col", o.col, 1);
    chk("first_row", o.row, 0);
    chk("first_ini", o.ini, 0);
    adv(1);
    o = get(0);
    chk("hold_tick", o.tick, 0);
    chk("hold_col", o.col, 1);
    run_table(0);
    chk("d2_no_ini", ini_q.size(), 0);
    rst0 = 1'b1;

    // ---- DIV=4, reduced geometry ----
    sel = 2;
    rst2 = 1'b0; k = 0; ini_q.delete();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      adv(1);
      o = get(2);
      if (o.tick != ((k % 4) == 0)) bad++;
      if (o.col != (k / 4) % 19) bad++;
    end
    chk("d4_tick_period", bad, 0);
    run_table(2);

    // Run through the end of the second frame against a position model.
    bad = 0; lines = 0; prev_row = 0;
    while (k < 1828) begin
      adv(1);
      o = get(2);
      n = k / 4;
      if (o.col != n % 19) bad++;
      if (o.row != (n / 19) % 12) bad++;
      if (o.vs != (((n / 19) % 12) >= 2)) bad++;
      if (o.ini && !o.tick) bad++;
      if (k > 912 && k <= 1824 && o.row != prev_row) lines++;
      prev_row = o.row;
    end
    chk("frame_model", bad, 0);
    chk("frame_lines", lines, 12);
    chk("ini_count", ini_q.size(), 2);
    er = (ini_q.size() > 0) ? ini_q[0] : -1;
    chk("ini_first_k", er, 912);
    er = (ini_q.size() > 1) ? ini_q[1] : -1;
    chk("ini_second_k", er, 1824);

    // Mid-frame reset at a non-zero divider phase.
    goto_n(2 * 228 + 6 * 19 + 10);
    o = get(2);
    chk("mid_col", o.col, 10);
    chk("mid_row", o.row, 6);
    chk("mid_vis", o.vis, 1);
    chk("mid_txt", o.txt, 1);
    adv(2);
    rst2 = 1'b1;
    adv(1);
    chk_rst("midrst");
    rst2 = 1'b0; k = 0; ini_q.delete();
    adv(3);
    o = get(2);
    chk("post_col0", o.col, 0);
    chk("post_tick0", o.tick, 0);
    adv(1);
    o = get(2);
    chk("post_col1", o.col, 1);
    chk("post_tick1", o.tick, 1);
    chk("post_ini", o.ini, 0);
    rst2 = 1'b1;

    // ---- DIV=1, default geometry ----
    sel = 1;
    rst1 = 1'b0; k = 0; ini_q.delete();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      adv(1);
      o = get(1);
      if (o.tick != 1'b1) bad++;
      if (o.col != k) bad++;
    end
    chk("d1_tick_const", bad, 0);
    run_table(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vga_barrido.md
# vga_barrido

Raster timing generator that sits directly upstream of the text-address stage. It divides the system clock into a pixel tick and runs horizontal and vertical counters. It emits registered HSYNC/VSYNC, the raw `Columnas`/`Filas` counts the address stage consumes, a visible-area flag and a text-window flag. All outputs are registered and change only on a pixel tick.

## Interface
- `DIV`, 2: system clocks per pixel; the tick rate is clk/DIV; DIV ≥ 1.
- `H_SYNC`, 128: HSYNC width, in pixels.
- `H_BACK`, 88: horizontal back porch.
- `H_VIS`, 800: visible columns.
- `H_FRONT`, 40: horizontal front porch.
- `V_SYNC`, 2: VSYNC width, in lines.
- `V_BACK`, 33: vertical back porch.
- `V_VIS`, 480: visible rows.
- `V_FRONT`, 10: vertical front porch.
- `SYNC_POL`, 0: active level of HSYNC/VSYNC (0 = active-low).
- `TXT_W`, 32 / `TXT_H`, 32: text window size in pixels, anchored at the first visible pixel.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `tick` out 1: one-clk pulse, every DIV clocks.
- `Columnas` out 11: horizontal count, 0..H_TOT-1.
- `Filas` out 10: vertical count, 0..V_TOT-1.
- `hsync` out 1: horizontal sync.
- `vsync` out 1: vertical sync.
- `visible` out 1: the current (Columnas, Filas) is inside the visible area.
- `en_texto` out 1: the current pixel is inside the text window.
- `inicio_cuadro` out 1: one-clk pulse on the tick where Columnas=0 and Filas=0.

## Operation
- Derived values:
  - H_TOT = H_SYNC+H_BACK+H_VIS+H_FRONT (default 1056).
  - V_TOT = V_SYNC+V_BACK+V_VIS+V_FRONT (default 525).
  - X0 = H_SYNC+H_BACK (216); Y0 = V_SYNC+V_BACK (35).
- Count origin is sync start: count 0 is the first sync pixel or line.
- Tick divider:
  - 0..DIV-1 modulo counter; `tick` is high when the counter equals DIV-1.
  - DIV=1 gives tick constantly high after reset.
- On each tick:
  - Columnas increments.
  - At H_TOT-1, Columnas wraps to 0 and Filas increments.
  - At Filas=V_TOT-1 with Columnas=H_TOT-1, both counters wrap to 0.
- Output decode is computed from the *next* counter values and registered in the same tick, so outputs always describe the Columnas/Filas being presented:
  - hsync active ⇔ Columnas < H_SYNC.
  - vsync active ⇔ Filas < V_SYNC.
  - visible ⇔ X0 ≤ Columnas < X0+H_VIS and Y0 ≤ Filas < Y0+V_VIS.
  - en_texto ⇔ X0 ≤ Columnas < X0+TXT_W and Y0 ≤ Filas < Y0+TXT_H.
- The downstream stage computes ((Filas-Y0)/2, (Columnas-X0)/2). It must be qualified by en_texto; outside the window its address is don't-care.
- Comparisons use unsigned arithmetic at counter width; no subtraction is done in this block.

## Timing
- Reset values (same clk edge as reset is sampled):
  - divider 0, Columnas 0, Filas 0.
  - hsync and vsync at their active level, because count (0,0) is sync.
  - visible 0, en_texto 0, tick 0, inicio_cuadro 0.
- First tick after reset release: DIV clocks after release (DIV=1: the first clk).
  - On that tick the counters advance to (1,0); inicio_cuadro is not pulsed.
  - The first inicio_cuadro occurs at the completion of the first full frame.
- Latency: 0 ticks between counters and flags; all are registered together.
- Outputs hold between ticks.
- Reset mid-frame: the next clk forces the reset state regardless of the divider phase; no partial line or pulse is emitted.
- Line wrap and frame wrap happen in the same tick, with no extra idle pixel.
- inicio_cuadro and tick are coincident.

## Structure
- Shared package `vga_pkg`:
  - default timing constants (H_*, V_*);
  - derived H_TOT, V_TOT, X0, Y0;
  - TXT_W, TXT_H.
  - The address stage uses X0/Y0 from `vga_pkg` instead of literals, so both stages agree.
- One natural sub-module: `vga_contador_eje`, instantiated twice (horizontal, vertical). It has:
  - parameters for sync, back porch, visible and front porch lengths;
  - inputs for count enable and wrap;
  - outputs for count, sync, visible and terminal count.

## Test plan
- **Reset, then idle for DIV-1 clocks.** Columnas=0, Filas=0, hsync=vsync=0 (active-low), visible=0, tick=0 throughout.
- **Defaults, run one line.** Checks on the row:
  - hsync low for Columnas 0..127, high from 128.
  - visible=0 at Columnas 215; visible=1 at Columnas 216 when Filas ≥ 35.
  - Columnas 1055 → 0 and Filas +1 on the same tick.
- **Run a full frame.** Checks:
  - vsync low only on Filas 0..1.
  - Exactly 525 lines.
  - inicio_cuadro pulses once, on the tick 1056×525 ticks after the preceding (0,0).
- **Text window.** Checks:
  - en_texto=1 at (216,35) and (247,66).
  - en_texto=0 at (248,35), (216,67) and (215,40).
- **Mid-frame reset.** Assert reset at (500,200) for 1 clk; the next clk shows (0,0) with all reset values.
- **DIV=1 and DIV=4 builds.** Checks:
  - tick period is 1 and 4 clks respectively.
  - Outputs change only on tick clks.
